stock_table_ctrl: RTL

Owns the vending machine's 8-entry stock table and shares it between the vend engine and the admin/restock port. It serialises their updates through one FSM and hands each committed table state to the persistence writer (stuff.txt dump) through a req/ack handshake. While a save is in progress the table is held frozen.

---
 rtl/vm_pkg.sv | 34 +++
 rtl/stock_table_ctrl_if.sv | 36 +++
 rtl/rr_arb2.sv | 37 +++
 rtl/stock_table_ctrl.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/vm_pkg.sv
// Shared constants and types for the vending machine stock table.
package vm_pkg;

  localparam int ITEM_W  = 11;
  localparam int N_ITEMS = 8;
  localparam int PRICE_W = 7;
  localparam int QTY_W   = 4;
  localparam int QTY_MAX = 15;
  localparam int SEL_W   = 3;
  localparam int TABLE_W = N_ITEMS * ITEM_W;

  typedef enum logic [1:0] {
    ADM_WRITE = 2'b00,
    ADM_ADD   = 2'b01,
    ADM_PRICE = 2'b10,
    ADM_RSVD  = 2'b11
  } adm_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_SAVE
  } ctrl_state_e;

  // Restock add: the sum is formed one bit wider so it can clamp instead of wrap.
  function automatic logic [QTY_W-1:0] qty_add_sat(input logic [QTY_W-1:0] qty,
                                                   input logic [QTY_W-1:0] add);
    logic [QTY_W:0] sum;
    sum = {1'b0, qty} + {1'b0, add};
    if (sum > (QTY_W+1)'(QTY_MAX)) return QTY_W'(QTY_MAX);
    else                           return sum[QTY_W-1:0];
  endfunction

endpackage

// File: rtl/stock_table_ctrl_if.sv
// Vend, admin and persistence-writer signals of the stock table controller.
interface stock_table_ctrl_if;
  import vm_pkg::*;

  logic               vend_req;
  logic [SEL_W-1:0]   vend_sel;
  logic               vend_ack;
  logic               vend_ok;
  logic [PRICE_W-1:0] vend_price;

  logic               adm_req;
  logic [1:0]         adm_op;
  logic [SEL_W-1:0]   adm_sel;
  logic [ITEM_W-1:0]  adm_data;
  logic               adm_ack;
  logic               adm_err;

  logic [TABLE_W-1:0] stock_table;
  logic               save_req;
  logic               save_ack;
  logic               save_err;
  logic               busy;

  modport slave (
    input  vend_req, vend_sel, adm_req, adm_op, adm_sel, adm_data, save_ack,
    output vend_ack, vend_ok, vend_price, adm_ack, adm_err,
           stock_table, save_req, save_err, busy
  );

  modport master (
    output vend_req, vend_sel, adm_req, adm_op, adm_sel, adm_data, save_ack,
    input  vend_ack, vend_ok, vend_price, adm_ack, adm_err,
           stock_table, save_req, save_err, busy
  );

endinterface

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter; on contention the side not served last wins.
module rr_arb2 (
  input  logic clock,
  input  logic reset,
  input  logic en,
  input  logic req_adm,
  input  logic req_vend,
  output logic gnt_adm,
  output logic gnt_vend
);

  logic last_vend;

  always_comb begin
    gnt_adm  = 1'b0;
    gnt_vend = 1'b0;
    if (en) begin
      if (req_adm && req_vend) begin
        gnt_vend = !last_vend;
        gnt_adm  = last_vend;
      end else begin
        gnt_adm  = req_adm;
        gnt_vend = req_vend;
      end
    end
  end

  // Reset pretends vend was served last so admin wins the first contention.
  always_ff @(posedge clock) begin
    if (reset) begin
      last_vend <= 1'b1;
    end else if (gnt_adm || gnt_vend) begin
      last_vend <= gnt_vend;
    end
  end

endmodule

// File: rtl/stock_table_ctrl.sv
// Stock table controller: serialises vend and admin updates of the 8-entry
// table and hands each changed table to the persistence writer.
module stock_table_ctrl
  import vm_pkg::*;
#(
  parameter logic [PRICE_W-1:0] RESET_PRICE  = 7'd10,
  parameter bit                 AUTO_SAVE    = 1'b1,
  parameter int unsigned        SAVE_TIMEOUT = 255
) (
  input  logic              clock,
  input  logic              reset,
  stock_table_ctrl_if.slave bus
);

  // state | meaning
  // IDLE  | arbitrating vend/admin requests
  // EXEC  | applying the latched op, pulsing its ack
  // SAVE  | save_req high, table frozen until save_ack or timeout

  // Down-counter loaded with SAVE_TIMEOUT-1 so terminal count lands on the
  // SAVE_TIMEOUT-th edge after save_req rose; SAVE_TIMEOUT must be >= 1.
  localparam int CNT_W = (SAVE_TIMEOUT > 2) ? $clog2(SAVE_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SAVE_TIMEOUT - 1);

  logic [N_ITEMS-1:0][ITEM_W-1:0] tbl;
  ctrl_state_e       state;
  logic              gnt_adm, gnt_vend;
  logic              is_vend_q;
  adm_op_e           op_q;
  logic [SEL_W-1:0]  sel_q;
  logic [ITEM_W-1:0] data_q;
  logic [CNT_W-1:0]  cnt;

  logic               vend_ack_q, vend_ok_q, adm_ack_q, adm_err_q;
  logic [PRICE_W-1:0] vend_price_q;
  logic               save_req_q, save_err_q, busy_q;

  logic [ITEM_W-1:0] cur_entry, new_entry;
  logic              changed;

  rr_arb2 u_arb (
    .clock    (clock),
    .reset    (reset),
    .en       (state == ST_IDLE),
    .req_adm  (bus.adm_req),
    .req_vend (bus.vend_req),
    .gnt_adm  (gnt_adm),
    .gnt_vend (gnt_vend)
  );

  always_comb begin
    cur_entry = tbl[sel_q];
    new_entry = cur_entry;
    changed   = 1'b0;
    if (is_vend_q) begin
      if (cur_entry[QTY_W-1:0] != '0) begin
        new_entry[QTY_W-1:0] = cur_entry[QTY_W-1:0] - QTY_W'(1);
        changed              = 1'b1;
      end
    end else begin
      case (op_q)
        ADM_WRITE: begin
          new_entry = data_q;
          changed   = 1'b1;
        end
        ADM_ADD: begin
          // Adding zero leaves the entry alone and must not trigger a save.
          if (data_q[QTY_W-1:0] != '0) begin
            new_entry[QTY_W-1:0] = qty_add_sat(cur_entry[QTY_W-1:0], data_q[QTY_W-1:0]);
            changed              = 1'b1;
          end
        end
        ADM_PRICE: begin
          new_entry[ITEM_W-1:QTY_W] = data_q[PRICE_W-1:0];
          changed                   = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= ST_IDLE;
      tbl          <= {N_ITEMS{RESET_PRICE, {QTY_W{1'b0}}}};
      is_vend_q    <= 1'b0;
      op_q         <= ADM_WRITE;
      sel_q        <= '0;
      data_q       <= '0;
      cnt          <= '0;
      vend_ack_q   <= 1'b0;
      vend_ok_q    <= 1'b0;
      vend_price_q <= '0;
      adm_ack_q    <= 1'b0;
      adm_err_q    <= 1'b0;
      save_req_q   <= 1'b0;
      save_err_q   <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      vend_ack_q   <= 1'b0;
      vend_ok_q    <= 1'b0;
      vend_price_q <= '0;
      adm_ack_q    <= 1'b0;
      adm_err_q    <= 1'b0;
      save_err_q   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (gnt_adm || gnt_vend) begin
            is_vend_q <= gnt_vend;
            op_q      <= adm_op_e'(bus.adm_op);
            sel_q     <= gnt_vend ? bus.vend_sel : bus.adm_sel;
            data_q    <= bus.adm_data;
            state     <= ST_EXEC;
            busy_q    <= 1'b1;
          end
        end
        ST_EXEC: begin
          tbl[sel_q]   <= new_entry;
          vend_ack_q   <= is_vend_q;
          vend_ok_q    <= is_vend_q && changed;
          vend_price_q <= is_vend_q ? cur_entry[ITEM_W-1:QTY_W] : '0;
          adm_ack_q    <= !is_vend_q;
          adm_err_q    <= !is_vend_q && (op_q == ADM_RSVD);
          if (changed && AUTO_SAVE) begin
            state      <= ST_SAVE;
            save_req_q <= 1'b1;
            cnt        <= CNT_LOAD;
          end else begin
            state  <= ST_IDLE;
            busy_q <= 1'b0;
          end
        end
        ST_SAVE: begin
          if (bus.save_ack) begin
            state      <= ST_IDLE;
            save_req_q <= 1'b0;
            busy_q     <= 1'b0;
          end else if (cnt == '0) begin
            state      <= ST_IDLE;
            save_req_q <= 1'b0;
            save_err_q <= 1'b1;
            busy_q     <= 1'b0;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: begin
          state  <= ST_IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.vend_ack    = vend_ack_q;
  assign bus.vend_ok     = vend_ok_q;
  assign bus.vend_price  = vend_price_q;
  assign bus.adm_ack     = adm_ack_q;
  assign bus.adm_err     = adm_err_q;
  assign bus.stock_table = tbl;
  assign bus.save_req    = save_req_q;
  assign bus.save_err    = save_err_q;
  assign bus.busy        = busy_q;

endmodule
